// File: rtl/gbt_pattern_gen_check.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : gbt_pattern_gen_check
//  Description : GBT link test-pattern generator and self-synchronising
//                checker. The generator drives the TX payload with one of
//                four patterns (counter, PRBS-31, walking-one, fixed). The
//                checker locks onto the returning RX word stream, then
//                reports per-word errors and saturating word/bit error counts.
//  Ports       : clk_ik        frame clock
//                rst_ir        asynchronous reset, active-high
//                mode_i        pattern select (00 cnt, 01 PRBS, 10 walk, 11 fixed)
//                tx_en_i       generator advance enable
//                clear_i       synchronous clear of checker state and counters
//                tx_data_o     generated word
//                tx_valid_o    tx_data_o holds a new word
//                rx_data_i     received word
//                rx_valid_i    rx_data_i valid this cycle
//                locked_o      checker is locked
//                err_o         one-cycle pulse per mismatching word while locked
//                err_seen_o    sticky error flag
//                err_words_o   saturating mismatching-word count
//                err_bits_o    saturating mismatching-bit count
//  Revision    : 1.0 - initial release
// ============================================================================
module gbt_pattern_gen_check #(
    parameter int                DATA_W        = 32,
    parameter int                ERRCNT_W      = 16,
    parameter int                LOCK_CNT      = 8,
    parameter int                UNLOCK_ERR    = 4,
    parameter logic [DATA_W-1:0] FIXED_PATTERN = DATA_W'(32'h5555_AAAA)
) (
    input  logic                clk_ik,
    input  logic                rst_ir,
    input  logic [1:0]          mode_i,
    input  logic                tx_en_i,
    input  logic                clear_i,
    output logic [DATA_W-1:0]   tx_data_o,
    output logic                tx_valid_o,
    input  logic [DATA_W-1:0]   rx_data_i,
    input  logic                rx_valid_i,
    output logic                locked_o,
    output logic                err_o,
    output logic                err_seen_o,
    output logic [ERRCNT_W-1:0] err_words_o,
    output logic [ERRCNT_W-1:0] err_bits_o
);

    localparam logic [1:0] c_MODE_CNT  = 2'b00;
    localparam logic [1:0] c_MODE_PRBS = 2'b01;
    localparam logic [1:0] c_MODE_WALK = 2'b10;

    localparam int c_GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int c_BAD_W  = $clog2(UNLOCK_ERR + 1);
    localparam int c_POP_W  = $clog2(DATA_W + 1);
    // One spare bit above the wider operand so the bit-count sum cannot wrap
    localparam int c_SUM_W  = ((ERRCNT_W > c_POP_W) ? ERRCNT_W : c_POP_W) + 1;
    localparam logic [ERRCNT_W-1:0] c_ERR_MAX = '1;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    function automatic logic [DATA_W-1:0] f_next(input logic [DATA_W-1:0] w,
                                                 input logic [1:0]        m);
        logic [DATA_W-1:0] n;
        n = '0;
        case (m)
            c_MODE_CNT:  n = w + DATA_W'(1);
            // Fibonacci x^31+x^28+1: feedback from taps 31 and 28 into bit 0
            c_MODE_PRBS: n[30:0] = {w[29:0], w[30] ^ w[27]};
            c_MODE_WALK: n = {w[DATA_W-2:0], w[DATA_W-1]};
            default:     n = FIXED_PATTERN;
        endcase
        return n;
    endfunction

    function automatic logic [DATA_W-1:0] f_seed(input logic [1:0] m);
        logic [DATA_W-1:0] s;
        s = '0;
        case (m)
            c_MODE_CNT:  s = '0;
            c_MODE_PRBS: s[30:0] = 31'h7FFF_FFFF;
            c_MODE_WALK: s = DATA_W'(1);
            default:     s = FIXED_PATTERN;
        endcase
        return s;
    endfunction

    state_t                r_state, w_state_nxt;
    logic [DATA_W-1:0]     r_exp, w_exp_nxt;
    logic [c_GOOD_W-1:0]   r_good, w_good_nxt;
    logic [c_BAD_W-1:0]    r_bad, w_bad_nxt;
    logic                  r_err, w_err_nxt;
    logic                  r_err_seen, w_seen_nxt;
    logic [ERRCNT_W-1:0]   r_err_words, w_words_nxt;
    logic [ERRCNT_W-1:0]   r_err_bits, w_bits_nxt;
    logic [1:0]            r_mode;
    logic [DATA_W-1:0]     r_tx_data;
    logic                  r_tx_valid;

    logic                  w_mode_chg;
    logic                  w_match;
    logic                  w_prbs_reject;
    logic [DATA_W-1:0]     w_diff;
    logic [c_POP_W-1:0]    w_popcnt;
    logic [c_SUM_W-1:0]    w_bits_sum;
    logic [ERRCNT_W-1:0]   w_bits_sat;
    logic [ERRCNT_W-1:0]   w_words_sat;

    assign w_mode_chg = (mode_i != r_mode);
    assign w_match    = (rx_data_i == r_exp);
    assign w_diff     = rx_data_i ^ r_exp;
    // The all-zero LFSR state is a lock-up state, and PRBS words never carry
    // upper bits: neither can be a legitimate starting point for a lock.
    assign w_prbs_reject = (mode_i == c_MODE_PRBS) &&
                           ((rx_data_i[30:0] == 31'd0) || (|rx_data_i[DATA_W-1:31]));

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_popcnt = w_popcnt + c_POP_W'(w_diff[i]);
        end
    end

    assign w_bits_sum  = c_SUM_W'(r_err_bits) + c_SUM_W'(w_popcnt);
    assign w_bits_sat  = (w_bits_sum > c_SUM_W'(c_ERR_MAX)) ? c_ERR_MAX
                                                           : w_bits_sum[ERRCNT_W-1:0];
    assign w_words_sat = (r_err_words == c_ERR_MAX) ? c_ERR_MAX
                                                    : r_err_words + ERRCNT_W'(1);

    // Checker next-state: clear beats mode change beats an incoming word.
    always_comb begin
        w_state_nxt = r_state;
        w_exp_nxt   = r_exp;
        w_good_nxt  = r_good;
        w_bad_nxt   = r_bad;
        w_err_nxt   = 1'b0;
        w_seen_nxt  = r_err_seen;
        w_words_nxt = r_err_words;
        w_bits_nxt  = r_err_bits;
        if (clear_i) begin
            w_state_nxt = ST_HUNT;
            w_good_nxt  = '0;
            w_bad_nxt   = '0;
            w_seen_nxt  = 1'b0;
            w_words_nxt = '0;
            w_bits_nxt  = '0;
        end else if (w_mode_chg) begin
            w_state_nxt = ST_HUNT;
            w_good_nxt  = '0;
            w_bad_nxt   = '0;
        end else if (rx_valid_i) begin
            case (r_state)
                ST_HUNT: begin
                    if (!w_prbs_reject) begin
                        w_exp_nxt   = f_next(rx_data_i, mode_i);
                        w_good_nxt  = c_GOOD_W'(1);
                        w_bad_nxt   = '0;
                        w_state_nxt = ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (w_match) begin
                        w_exp_nxt  = f_next(r_exp, mode_i);
                        w_good_nxt = r_good + c_GOOD_W'(1);
                        if (r_good == c_GOOD_W'(LOCK_CNT - 1)) begin
                            w_state_nxt = ST_LOCKED;
                            w_bad_nxt   = '0;
                        end
                    end else begin
                        w_exp_nxt  = f_next(rx_data_i, mode_i);
                        w_good_nxt = c_GOOD_W'(1);
                    end
                end
                ST_LOCKED: begin
                    // Expected value free-runs; it is never resynced to rx here
                    w_exp_nxt = f_next(r_exp, mode_i);
                    if (w_match) begin
                        w_bad_nxt = '0;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_seen_nxt  = 1'b1;
                        w_words_nxt = w_words_sat;
                        w_bits_nxt  = w_bits_sat;
                        if (r_bad == c_BAD_W'(UNLOCK_ERR - 1)) begin
                            w_state_nxt = ST_HUNT;
                            w_bad_nxt   = '0;
                            w_good_nxt  = '0;
                        end else begin
                            w_bad_nxt = r_bad + c_BAD_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk_ik or posedge rst_ir) begin
        if (rst_ir) begin
            r_state     <= ST_HUNT;
            r_exp       <= '0;
            r_good      <= '0;
            r_bad       <= '0;
            r_err       <= 1'b0;
            r_err_seen  <= 1'b0;
            r_err_words <= '0;
            r_err_bits  <= '0;
            r_mode      <= c_MODE_CNT;
            r_tx_data   <= '0;
            r_tx_valid  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_exp       <= w_exp_nxt;
            r_good      <= w_good_nxt;
            r_bad       <= w_bad_nxt;
            r_err       <= w_err_nxt;
            r_err_seen  <= w_seen_nxt;
            r_err_words <= w_words_nxt;
            r_err_bits  <= w_bits_nxt;
            r_mode      <= mode_i;
            r_tx_valid  <= tx_en_i;
            if (w_mode_chg) begin
                r_tx_data <= f_seed(mode_i);
            end else if (tx_en_i) begin
                r_tx_data <= f_next(r_tx_data, mode_i);
            end
        end
    end

    assign tx_data_o   = r_tx_data;
    assign tx_valid_o  = r_tx_valid;
    assign locked_o    = (r_state == ST_LOCKED);
    assign err_o       = r_err;
    assign err_seen_o  = r_err_seen;
    assign err_words_o = r_err_words;
    assign err_bits_o  = r_err_bits;

endmodule
`default_nettype wire

// File: tb/tb_gbt_pattern_gen_check.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_gbt_pattern_gen_check
//  Description : Scoreboard bench for gbt_pattern_gen_check. Stimulus pushes
//                expected TX words and expected checker status per RX word;
//                a monitor pops and compares whenever the DUT presents them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gbt_pattern_gen_check;

    localparam int DW = 32;
    localparam int EW = 4;

    logic          clk_ik = 1'b0;
    logic          rst_ir = 1'b1;
    logic [1:0]    mode_i = 2'b00;
    logic          tx_en_i = 1'b0;
    logic          clear_i = 1'b0;
    logic [DW-1:0] tx_data_o;
    logic          tx_valid_o;
    logic [DW-1:0] rx_data_i = '0;
    logic          rx_valid_i = 1'b0;
    logic          locked_o;
    logic          err_o;
    logic          err_seen_o;
    logic [EW-1:0] err_words_o;
    logic [EW-1:0] err_bits_o;

    gbt_pattern_gen_check #(
        .DATA_W     (DW),
        .ERRCNT_W   (EW),
        .LOCK_CNT   (8),
        .UNLOCK_ERR (4)
    ) dut (
        .clk_ik      (clk_ik),
        .rst_ir      (rst_ir),
        .mode_i      (mode_i),
        .tx_en_i     (tx_en_i),
        .clear_i     (clear_i),
        .tx_data_o   (tx_data_o),
        .tx_valid_o  (tx_valid_o),
        .rx_data_i   (rx_data_i),
        .rx_valid_i  (rx_valid_i),
        .locked_o    (locked_o),
        .err_o       (err_o),
        .err_seen_o  (err_seen_o),
        .err_words_o (err_words_o),
        .err_bits_o  (err_bits_o)
    );

    always #5 clk_ik = ~clk_ik;

    typedef struct packed {
        logic          locked;
        logic          err;
        logic          seen;
        logic [EW-1:0] words;
        logic [EW-1:0] bits;
    } stat_t;

    stat_t         rx_q[$];
    logic [DW-1:0] tx_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    logic          prev_rxv;
    logic [DW-1:0] tx_ref = '0;
    logic [1:0]    cur_mode = 2'b00;
    logic [DW-1:0] cv;
    logic [DW-1:0] p;
    logic [DW-1:0] wk;
    int            nbad;

    function automatic stat_t st(input logic l, input logic e, input logic s,
                                 input int w, input int b);
        stat_t r;
        r.locked = l;
        r.err    = e;
        r.seen   = s;
        r.words  = EW'(w);
        r.bits   = EW'(b);
        return r;
    endfunction

    function automatic logic [DW-1:0] prbs(input logic [DW-1:0] w);
        return {1'b0, w[29:0], w[30] ^ w[27]};
    endfunction

    function automatic logic [DW-1:0] ref_next(input logic [DW-1:0] w, input logic [1:0] m);
        case (m)
            2'b00:   return w + 32'd1;
            2'b01:   return prbs(w);
            2'b10:   return {w[DW-2:0], w[DW-1]};
            default: return 32'h5555_AAAA;
        endcase
    endfunction

    function automatic logic [DW-1:0] ref_seed(input logic [1:0] m);
        case (m)
            2'b00:   return 32'd0;
            2'b01:   return 32'h7FFF_FFFF;
            2'b10:   return 32'd1;
            default: return 32'h5555_AAAA;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; expectations are queued before the edge.
    task automatic step(input logic txen, input logic rxv, input logic [DW-1:0] rxd,
                        input stat_t e);
        tx_en_i    = txen;
        rx_valid_i = rxv;
        rx_data_i  = rxd;
        if (mode_i != cur_mode) begin
            tx_ref   = ref_seed(mode_i);
            cur_mode = mode_i;
        end else if (txen) begin
            tx_ref = ref_next(tx_ref, cur_mode);
        end
        if (txen) tx_q.push_back(tx_ref);
        if (rxv)  rx_q.push_back(e);
        @(posedge clk_ik);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        idle();
        clear_i = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_locked"}, 64'(locked_o), 64'd0);
        check({tag, "_seen"},   64'(err_seen_o), 64'd0);
        check({tag, "_words"},  64'(err_words_o), 64'd0);
        check({tag, "_bits"},   64'(err_bits_o), 64'd0);
    endtask

    // Monitor: one checker status per accepted RX word, one TX word per tx_valid_o
    always @(posedge clk_ik or posedge rst_ir) begin
        if (rst_ir) prev_rxv <= 1'b0;
        else        prev_rxv <= rx_valid_i;
    end

    always @(negedge clk_ik) begin : mon
        stat_t e;
        stat_t a;
        logic [DW-1:0] t;
        if (prev_rxv) begin
            n_vec++;
            if (rx_q.size() == 0) begin
                n_err++;
                $display("FAIL rx_status: DUT status with no expected entry");
            end else begin
                e = rx_q.pop_front();
                a = {locked_o, err_o, err_seen_o, err_words_o, err_bits_o};
                if (a !== e) begin
                    n_err++;
                    $display("FAIL rx_status @%0t: got lock=%b err=%b seen=%b words=%0d bits=%0d, expected lock=%b err=%b seen=%b words=%0d bits=%0d",
                             $time, a.locked, a.err, a.seen, a.words, a.bits,
                             e.locked, e.err, e.seen, e.words, e.bits);
                end
            end
        end
        if (tx_valid_o) begin
            n_vec++;
            if (tx_q.size() == 0) begin
                n_err++;
                $display("FAIL tx_word: tx_valid_o with no expected entry, data %0h", tx_data_o);
            end else begin
                t = tx_q.pop_front();
                if (tx_data_o !== t) begin
                    n_err++;
                    $display("FAIL tx_word @%0t: got %0h, expected %0h", $time, tx_data_o, t);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk_ik);
        #1;
        rst_ir = 1'b0;
        check("rst_tx_data",  64'(tx_data_o), 64'd0);
        check("rst_tx_valid", 64'(tx_valid_o), 64'd0);
        check("rst_err",      64'(err_o), 64'd0);
        check_cleared("rst");

        // Counter loopback, 1000 words
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, 1'b1, DW'(i + 1), st(i >= 7, 1'b0, 1'b0, 0, 0));
        end
        idle();
        cv = 32'd1001;

        // Single-bit then three-bit corruption while locked
        step(1'b0, 1'b1, cv ^ 32'h20, st(1, 1, 1, 1, 1)); cv++;
        step(1'b0, 1'b1, cv ^ 32'h7,  st(1, 1, 1, 2, 4)); cv++;
        step(1'b0, 1'b1, cv,          st(1, 0, 1, 2, 4)); cv++;

        // Four consecutive bad words force relock
        do_clear();
        check_cleared("clr1");
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, cv, st(i >= 7, 0, 0, 0, 0)); cv++;
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, cv ^ 32'h20, st(i < 3, 1, 1, i + 1, i + 1)); cv++;
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, cv, st(i >= 7, 0, 1, 4, 4)); cv++;
        end

        // PRBS: generator seed sequence and mid-sequence lock
        mode_i = 2'b01;
        step(1'b1, 1'b0, '0, '0);
        p = 32'h1234_5678;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, p, st(i >= 7, 0, 1, 4, 4));
            p = prbs(p);
        end
        do_clear();
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b1, '0, st(0, 0, 0, 0, 0));
        end
        // Valid low bits with bit 31 set must not seed the checker
        step(1'b0, 1'b1, p | 32'h8000_0000, st(0, 0, 0, 0, 0));
        p = prbs(p);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, p, st(i >= 7, 0, 0, 0, 0));
            p = prbs(p);
        end

        // Saturation with ERRCNT_W = 4
        mode_i = 2'b00;
        idle();
        do_clear();
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, cv, st(i >= 7, 0, 0, 0, 0)); cv++;
        end
        nbad = 0;
        for (int g = 0; g < 6; g++) begin
            for (int k = 0; k < 3; k++) begin
                nbad++;
                step(1'b0, 1'b1, ~cv, st(1, 1, 1, (nbad > 15) ? 15 : nbad, 15)); cv++;
            end
            step(1'b0, 1'b1, cv, st(1, 0, 1, (nbad > 15) ? 15 : nbad, 15)); cv++;
        end
        do_clear();
        check_cleared("clr_sat");

        // Asynchronous reset mid-lock
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, cv, st(i >= 7, 0, 0, 0, 0)); cv++;
        end
        step(1'b0, 1'b1, cv ^ 32'h1, st(1, 1, 1, 1, 1)); cv++;
        idle();
        #2;
        rst_ir = 1'b1;
        #1;
        check("arst_tx_data", 64'(tx_data_o), 64'd0);
        check("arst_err",     64'(err_o), 64'd0);
        check_cleared("arst");
        tx_ref   = '0;
        cur_mode = 2'b00;
        @(posedge clk_ik);
        #1;
        rst_ir = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, cv, st(i >= 7, 0, 0, 0, 0)); cv++;
        end

        // Mode change 00 -> 10: generator restarts at 1, checker relocks
        mode_i = 2'b10;
        step(1'b1, 1'b0, '0, '0);
        wk = 32'd1;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, wk, st(i >= 7, 0, 0, 0, 0));
            wk = {wk[DW-2:0], wk[DW-1]};
        end
        idle();
        idle();

        for (int k = 0; k < 20 && (rx_q.size() != 0 || tx_q.size() != 0); k++) begin
            @(posedge clk_ik);
        end
        if (rx_q.size() != 0 || tx_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d rx and %0d tx expectations never observed, expected 0",
                     rx_q.size(), tx_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
